// File: rtl/rr_burst_sched_pkg.sv
// rtl/rr_burst_sched_pkg.sv - shared types, constants and helpers for rr_burst_sched
//
// Purpose : state encoding, grant-index width and the one-hot expansion
//           helper used by the burst scheduler and its arbiter.
// Contents:
//   GID_W    width of the binary grant index (supports up to 8 requesters)
//   MAX_REQ  largest requester count the index width can address
//   S_*      state encodings, state_t enum built from them
//   onehot() index -> one-hot vector of MAX_REQ bits
package rr_burst_sched_pkg;

   localparam int GID_W   = 3;
   localparam int MAX_REQ = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_REL   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_GRANT = S_GRANT,
      ST_XFER  = S_XFER,
      ST_REL   = S_REL
   } state_t;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [GID_W-1:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority requester search
//
// Purpose : returns the first asserted request at or above the priority
//           pointer, falling back to the lowest asserted request when none
//           exists at or above it. Purely combinational, no state.
// Ports   :
//   req      in  N_REQ  request vector
//   ptr      in  GID_W  index holding highest priority
//   win_id   out GID_W  winning index (0 when win_vld is low)
//   win_vld  out 1      at least one request asserted
module rr_pick
   import rr_burst_sched_pkg::*;
#(
   parameter int N_REQ = 5
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GID_W-1:0] ptr,
   output logic [GID_W-1:0] win_id,
   output logic             win_vld
);

   logic found;

   always_comb begin
      win_id = '0;
      found  = 1'b0;
      // Pass 1: requests at or above the pointer, in ascending order.
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (GID_W'(i) >= ptr)) begin
            win_id = GID_W'(i);
            found  = 1'b1;
         end
      end
      // Pass 2: wrap around to the lowest asserted request.
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i]) begin
            win_id = GID_W'(i);
            found  = 1'b1;
         end
      end
      win_vld = |req;
   end

endmodule

// File: rtl/rr_burst_sched.sv
// rtl/rr_burst_sched.sv - burst-level round-robin scheduler for one shared resource
//
// Purpose : arbitrates N_REQ requesters for a single-port resource. A winner
//           is chosen in IDLE with rotating priority, its burst length is
//           latched, and the grant is held until length+1 beats are accepted
//           or the stall watchdog expires. Priority then moves past the
//           winner.
// Ports   :
//   CLK       in  1            clock
//   XRST      in  1            synchronous active-low reset
//   REQ       in  N_REQ        request levels (sampled in IDLE only)
//   REQ_LEN   in  N_REQ*LEN_W  burst length-1 per requester, slice i at [i*LEN_W +: LEN_W]
//   BEAT_VLD  in  1            resource accepted a beat (counted in XFER only)
//   GNT       out N_REQ        registered one-hot grant
//   GNT_ID    out GID_W        index of granted requester, held while GNT==0
//   BUSY      out 1            high in GRANT and XFER
//   DONE      out 1            one-cycle pulse, burst completed
//   TO_ERR    out 1            one-cycle pulse, burst aborted by watchdog
module rr_burst_sched
   import rr_burst_sched_pkg::*;
#(
   parameter int N_REQ  = 5,
   parameter int LEN_W  = 4,
   parameter int TO_CYC = 64
) (
   input  logic                   CLK,
   input  logic                   XRST,
   input  logic [N_REQ-1:0]       REQ,
   input  logic [N_REQ*LEN_W-1:0] REQ_LEN,
   input  logic                   BEAT_VLD,
   output logic [N_REQ-1:0]       GNT,
   output logic [GID_W-1:0]       GNT_ID,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   TO_ERR
);

   localparam int               TO_W    = $clog2(TO_CYC);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);
   localparam logic [GID_W-1:0] LAST_ID = GID_W'(N_REQ - 1);

   state_t             state;
   logic [GID_W-1:0]   ptr;
   logic [LEN_W-1:0]   beat_cnt;
   logic [TO_W-1:0]    to_cnt;

   logic [GID_W-1:0]   pick_id;
   logic               pick_vld;
   logic [LEN_W-1:0]   pick_len;

   rr_pick #(
      .N_REQ   (N_REQ)
   ) u_pick (
      .req     (REQ),
      .ptr     (ptr),
      .win_id  (pick_id),
      .win_vld (pick_vld)
   );

   // Length field of the current winner.
   always_comb begin
      pick_len = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (GID_W'(i) == pick_id) begin
            pick_len = REQ_LEN[i*LEN_W +: LEN_W];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!XRST) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         beat_cnt <= '0;
         to_cnt   <= '0;
         GNT      <= '0;
         GNT_ID   <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         TO_ERR   <= 1'b0;
      end else begin
         DONE   <= 1'b0;
         TO_ERR <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  // Grant registers load here so they are visible in GRANT.
                  GNT      <= N_REQ'(onehot(pick_id));
                  GNT_ID   <= pick_id;
                  BUSY     <= 1'b1;
                  beat_cnt <= pick_len;
                  to_cnt   <= '0;
                  ptr      <= (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
                  state    <= ST_GRANT;
               end
            end

            ST_GRANT: begin
               to_cnt <= '0;
               state  <= ST_XFER;
            end

            ST_XFER: begin
               if (BEAT_VLD) begin
                  to_cnt <= '0;
                  if (beat_cnt == '0) begin
                     GNT   <= '0;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                     state <= ST_REL;
                  end else begin
                     beat_cnt <= beat_cnt - 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  // TO_CYC consecutive beat-less XFER cycles: abandon burst.
                  GNT    <= '0;
                  BUSY   <= 1'b0;
                  TO_ERR <= 1'b1;
                  state  <= ST_REL;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            ST_REL: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_burst_sched.sv
// tb/tb_rr_burst_sched.sv - self-checking bench for rr_burst_sched
module tb_rr_burst_sched;

   localparam int N_REQ  = 5;
   localparam int LEN_W  = 4;
   localparam int TO_CYC = 64;
   localparam int LW_ALL = N_REQ * LEN_W;

   logic                CLK = 1'b0;
   logic                XRST;
   logic [N_REQ-1:0]    REQ;
   logic [LW_ALL-1:0]   REQ_LEN;
   logic                BEAT_VLD;
   logic [N_REQ-1:0]    GNT;
   logic [2:0]          GNT_ID;
   logic                BUSY;
   logic                DONE;
   logic                TO_ERR;

   int n_tests  = 0;
   int n_fail   = 0;
   int ptr_m    = 0;   // model priority pointer
   int last_win = 0;   // model of the held grant index

   rr_burst_sched #(
      .N_REQ    (N_REQ),
      .LEN_W    (LEN_W),
      .TO_CYC   (TO_CYC)
   ) dut (
      .CLK      (CLK),
      .XRST     (XRST),
      .REQ      (REQ),
      .REQ_LEN  (REQ_LEN),
      .BEAT_VLD (BEAT_VLD),
      .GNT      (GNT),
      .GNT_ID   (GNT_ID),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .TO_ERR   (TO_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Scan upward from the pointer, wrapping modulo N_REQ.
   function automatic int model_pick(input logic [N_REQ-1:0] r);
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (ptr_m + k) % N_REQ;
         if (r[idx]) return idx;
      end
      return 0;
   endfunction

   function automatic logic [LW_ALL-1:0] all_len(input int l);
      logic [LW_ALL-1:0] v;
      for (int i = 0; i < N_REQ; i++) v[i*LEN_W +: LEN_W] = LEN_W'(l);
      return v;
   endfunction

   task automatic apply_reset();
      XRST     = 1'b0;
      REQ      = N_REQ'($urandom);
      REQ_LEN  = LW_ALL'($urandom);
      BEAT_VLD = 1'b1;
      step();
      step();
      n_tests++;
      if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset: gnt=%b id=%0d busy=%b done=%b to=%b, want all zero",
                  GNT, GNT_ID, BUSY, DONE, TO_ERR);
      end
      XRST     = 1'b1;
      REQ      = '0;
      BEAT_VLD = 1'b0;
      step();
      n_tests++;
      if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_release: gnt=%b id=%0d busy=%b done=%b to=%b, want all zero",
                  GNT, GNT_ID, BUSY, DONE, TO_ERR);
      end
      ptr_m    = 0;
      last_win = 0;
   endtask

   // One complete burst starting with the DUT idle. The first idle_lead XFER
   // cycles carry no beat; afterwards a beat is offered with pct% chance.
   task automatic run_burst(input logic [N_REQ-1:0] req, input logic [LW_ALL-1:0] lens,
                            input int pct, input int idle_lead, input bit perturb);
      int win, len, beats_left, idle_run, cyc;
      bit ended, ab, b;
      logic [N_REQ-1:0] eg;
      win = model_pick(req);
      len = int'(lens[win*LEN_W +: LEN_W]);
      eg  = N_REQ'(1) << win;
      REQ      = req;
      REQ_LEN  = lens;
      BEAT_VLD = 1'($urandom);
      step();
      n_tests++;
      if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== {eg, 3'(win), 3'b100}) begin
         n_fail++;
         $display("FAIL grant: gnt=%b id=%0d busy=%b done=%b to=%b, want gnt=%b id=%0d busy=1",
                  GNT, GNT_ID, BUSY, DONE, TO_ERR, eg, win);
      end
      ptr_m    = (win + 1) % N_REQ;
      last_win = win;
      if (perturb) begin
         REQ     = N_REQ'($urandom);
         REQ_LEN = LW_ALL'($urandom);
      end
      BEAT_VLD = 1'b1;   // GRANT-cycle beat must not be counted
      step();
      n_tests++;
      if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== {eg, 3'(win), 3'b100}) begin
         n_fail++;
         $display("FAIL xfer_entry: gnt=%b id=%0d busy=%b done=%b to=%b, want gnt=%b id=%0d busy=1",
                  GNT, GNT_ID, BUSY, DONE, TO_ERR, eg, win);
      end
      beats_left = len + 1;
      idle_run   = 0;
      ended      = 1'b0;
      ab         = 1'b0;
      cyc        = 0;
      while (!ended && cyc < 4000) begin
         b = (cyc >= idle_lead) && ($urandom_range(0, 99) < pct);
         BEAT_VLD = b;
         if (perturb) begin
            REQ     = N_REQ'($urandom);
            REQ_LEN = LW_ALL'($urandom);
         end
         step();
         cyc++;
         if (b) begin
            beats_left--;
            idle_run = 0;
         end else begin
            idle_run++;
         end
         if (beats_left == 0) begin
            ended = 1'b1;
         end else if (idle_run == TO_CYC) begin
            ended = 1'b1;
            ab    = 1'b1;
         end
         n_tests++;
         if (!ended) begin
            if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== {eg, 3'(win), 3'b100}) begin
               n_fail++;
               $display("FAIL xfer_hold: cyc=%0d gnt=%b id=%0d busy=%b done=%b to=%b, want gnt=%b id=%0d busy=1",
                        cyc, GNT, GNT_ID, BUSY, DONE, TO_ERR, eg, win);
            end
         end else begin
            if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== {N_REQ'(0), 3'(win), 1'b0, !ab, ab}) begin
               n_fail++;
               $display("FAIL release: cyc=%0d gnt=%b id=%0d busy=%b done=%b to=%b, want gnt=0 id=%0d done=%b to=%b",
                        cyc, GNT, GNT_ID, BUSY, DONE, TO_ERR, win, !ab, ab);
            end
         end
      end
      if (!ended) begin
         n_tests++;
         n_fail++;
         $display("FAIL burst_bound: burst model never ended");
      end
      // REL cycle: request and beat inputs must be ignored.
      REQ      = N_REQ'($urandom);
      BEAT_VLD = 1'($urandom);
      step();
      n_tests++;
      if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== {N_REQ'(0), 3'(win), 3'b000}) begin
         n_fail++;
         $display("FAIL idle_gap: gnt=%b id=%0d busy=%b done=%b to=%b, want gnt=0 id=%0d no pulses",
                  GNT, GNT_ID, BUSY, DONE, TO_ERR, win);
      end
      REQ      = '0;
      BEAT_VLD = 1'b0;
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         REQ      = '0;
         BEAT_VLD = 1'($urandom);
         step();
         n_tests++;
         if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== {N_REQ'(0), 3'(last_win), 3'b000}) begin
            n_fail++;
            $display("FAIL idle_hold: gnt=%b id=%0d busy=%b done=%b to=%b, want gnt=0 id=%0d",
                     GNT, GNT_ID, BUSY, DONE, TO_ERR, last_win);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_single_len3();
      logic [LW_ALL-1:0] l;
      apply_reset();
      l = '0;
      l[2*LEN_W +: LEN_W] = 4'd3;
      run_burst(5'b00100, l, 100, 0, 1'b0);
      run_burst(5'b11111, all_len(0), 100, 0, 1'b0);   // pointer now at 3
   endtask

   task automatic test_all_req();
      apply_reset();
      for (int i = 0; i < 6; i++) run_burst(5'b11111, all_len(0), 100, 0, 1'b0);
   endtask

   task automatic test_wrap();
      apply_reset();
      run_burst(5'b00100, all_len(1), 100, 0, 1'b0);
      run_burst(5'b00011, all_len(1), 100, 0, 1'b0);
      run_burst(5'b00011, all_len(1), 100, 0, 1'b0);
   endtask

   task automatic test_timeout();
      apply_reset();
      run_burst(5'b00010, all_len(7), 0, 0, 1'b0);
      run_burst(5'b00100, all_len(1), 100, TO_CYC - 1, 1'b0);   // just survives
      run_burst(5'b01000, all_len(1), 100, TO_CYC, 1'b0);       // just aborts
   endtask

   task automatic test_reset_mid();
      logic [LW_ALL-1:0] l;
      apply_reset();
      run_burst(5'b00100, all_len(0), 100, 0, 1'b0);   // pointer to 3
      l = all_len(7);
      REQ      = 5'b01000;
      REQ_LEN  = l;
      BEAT_VLD = 1'b0;
      step();                    // GRANT
      BEAT_VLD = 1'b1;
      step();                    // XFER
      step();                    // beat 1
      step();                    // beat 2
      XRST     = 1'b0;
      step();
      n_tests++;
      if ({GNT, GNT_ID, BUSY, DONE, TO_ERR} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_mid: gnt=%b id=%0d busy=%b done=%b to=%b, want all zero",
                  GNT, GNT_ID, BUSY, DONE, TO_ERR);
      end
      XRST     = 1'b1;
      REQ      = '0;
      step();
      n_tests++;
      if ({GNT, BUSY, DONE, TO_ERR} !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: gnt=%b busy=%b done=%b to=%b, want zero",
                  GNT, BUSY, DONE, TO_ERR);
      end
      ptr_m    = 0;
      last_win = 0;
      run_burst(5'b10001, all_len(2), 100, 0, 1'b0);   // pointer reset gives 0
   endtask

   task automatic test_ignore_changes();
      logic [LW_ALL-1:0] l;
      apply_reset();
      l = all_len(1);
      l[4*LEN_W +: LEN_W] = 4'd5;
      run_burst(5'b10000, l, 100, 0, 1'b1);
      run_burst(5'b11111, all_len(0), 100, 0, 1'b0);   // pointer wrapped to 0
   endtask

   task automatic test_max_len();
      apply_reset();
      run_burst(5'b00001, all_len(15), 100, 0, 1'b0);
      run_burst(5'b00001, all_len(15), 60, 0, 1'b0);   // single requester re-granted
   endtask

   task automatic test_random();
      logic [N_REQ-1:0] r;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         idle_cycles($urandom_range(0, 3));
         r = N_REQ'($urandom);
         if (r == '0) r = N_REQ'(1) << $urandom_range(0, N_REQ - 1);
         run_burst(r, LW_ALL'($urandom), $urandom_range(20, 100), 0, 1'($urandom));
      end
   endtask

   initial begin
      XRST     = 1'b0;
      REQ      = '0;
      REQ_LEN  = '0;
      BEAT_VLD = 1'b0;
      test_reset();
      test_single_len3();
      test_all_req();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_ignore_changes();
      test_max_len();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_burst_sched.md
Name: rr_burst_sched

Overview:
Burst-level round-robin scheduler that shares one single-port resource, such as a memory or bus port, between N requesters. It picks one requester with a rotating-priority arbiter and latches that requester's burst length. It holds a one-hot grant until that many beats have been accepted by the resource, or until a stall watchdog fires. It then releases the grant and rotates priority. It sits between the client request lines and the shared resource's beat handshake.

Parameters:
N_REQ, 5, number of requesters (2..8)
LEN_W, 4, burst-length field width; field value L means L+1 beats
TO_CYC, 64, max consecutive XFER cycles without BEAT_VLD before abort (>=2)

Ports:
CLK  in  1  clock
XRST  in  1  reset, synchronous, active-low
REQ  in  N_REQ  per-requester request level
REQ_LEN  in  N_REQ*LEN_W  per-requester burst length-1; slice i = bits [i*LEN_W +: LEN_W]
BEAT_VLD  in  1  resource accepted one beat this cycle (meaningful only while GNT != 0)
GNT  out  N_REQ  registered one-hot grant
GNT_ID  out  3  binary index of granted requester (valid while GNT != 0)
BUSY  out  1  high in GRANT and XFER states
DONE  out  1  one-cycle pulse: burst ended normally
TO_ERR  out  1  one-cycle pulse: burst aborted by watchdog

Behaviour:
- Reset (XRST=0 at a clock edge):
  - state=IDLE; GNT=0, GNT_ID=0, BUSY=0, DONE=0, TO_ERR=0.
  - pointer=0, so requester 0 has highest priority.
  - beat and timeout counters cleared.
  - Reset mid-burst aborts immediately, with no DONE or TO_ERR pulse.
- FSM states: IDLE, GRANT, XFER, REL.
- IDLE:
  - If |REQ, the rotating-priority winner is computed combinationally: first set REQ bit at index >= pointer, else the lowest set index.
  - Latched at the edge: win_id; beat_cnt = REQ_LEN[win_id]; pointer = (win_id==N_REQ-1) ? 0 : win_id+1.
  - Next state GRANT.
- GRANT: GNT = onehot(win_id), GNT_ID = win_id, BUSY=1. Latency is one cycle from REQ sampled to GNT visible. Next state XFER.
- XFER:
  - GNT held stable.
  - BEAT_VLD=1 with beat_cnt==0 → REL with normal completion; otherwise BEAT_VLD=1 decrements beat_cnt.
  - Timeout counter clears on each BEAT_VLD and increments otherwise. When it reaches TO_CYC-1 with BEAT_VLD=0 → REL with abort flag set.
- REL:
  - GNT=0, BUSY=0.
  - DONE=1 if normal completion, else TO_ERR=1; never both.
  - Next state IDLE.
  - Minimum grant-to-grant gap: GRANT→XFER→REL→IDLE→GRANT, i.e. 2 non-granted cycles between consecutive bursts.
- REQ and REQ_LEN are sampled only in IDLE. Requester deassertion during a burst is ignored. Length changes during a burst are ignored.
- BEAT_VLD outside XFER is ignored.
- Single requester always active: re-granted every burst; the pointer wraps past it and returns to it.
- All N_REQ requesting: grants cycle 0,1,..,N_REQ-1,0.
- A winning REQ_LEN of 0 gives a 1-beat burst; the maximum burst is 2^LEN_W beats.
- GNT is never multi-hot. GNT_ID is held at its last value when GNT=0.
- Counter widths: beat_cnt is LEN_W bits; the timeout counter is clog2(TO_CYC) bits with no wrap.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, GRANT=2'd1, XFER=2'd2, REL=2'd3);
  - the GNT_ID width constant (3);
  - a onehot-from-index function.
- One sub-module: rr_pick. It is purely combinational and holds the rotating-priority search (inputs REQ, pointer; outputs win_id, win_vld). It is reusable by other schedulers.
- The FSM, counters and pointer register stay in rr_burst_sched.

Test Plan:
- Reset then REQ=5'b00100, REQ_LEN[2]=3, BEAT_VLD=1 continuous → GNT=5'b00100 one cycle after REQ; exactly 4 beats consumed; DONE pulses once; pointer=3.
- REQ=5'b11111 held, all lengths 0, BEAT_VLD=1 → GNT_ID sequence 0,1,2,3,4,0; each grant 1 cycle wide (the XFER cycle) after GRANT; 2 idle cycles between grants.
- Pointer=3, REQ=5'b00011 → grant goes to 0 (wrap), then 1 on the next burst.
- Grant to 1 with REQ_LEN=7; BEAT_VLD held 0 → TO_ERR pulses after 64 XFER cycles; DONE stays 0; GNT drops in the same cycle as the TO_ERR pulse.
- Mid-burst (beat 2 of 8): XRST=0 for 1 cycle → next cycle GNT=0, BUSY=0, no DONE; after release with REQ=5'b00001, requester 0 is granted (pointer reset).
- Grant to 4, REQ[4] dropped after GRANT, REQ_LEN[4] changed → burst still completes at the originally latched length; DONE pulses; pointer=0.
